// File: rtl/reservation_stations.sv
// Four-entry reservation station with CDB wakeup, dispatch bypass and flush.
// Ports: clk/reset, flush, dispatch_*/d_*, cdb_*, consumed_bus -> rsN_data, occupancy.
package rs_pkg;
   localparam logic [2:0] NB = 3'b111;

   typedef struct packed {
      logic        valid_operands;
      logic [3:0]  ALU_op;
      logic        load;
      logic [2:0]  branch_type;
      logic [3:0]  ROB_entry;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } rs_out_t;

   typedef struct packed {
      logic        busy;
      logic [3:0]  alu;
      logic        load;
      logic [2:0]  br;
      logic [3:0]  rob;
      logic [31:0] v1;
      logic        r1;
      logic [3:0]  t1;
      logic [31:0] v2;
      logic        r2;
      logic [3:0]  t2;
   } rs_ent_t;
endpackage

module reservation_stations
   import rs_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        dispatch_valid,
   output logic        dispatch_ready,
   input  logic [3:0]  d_ALU_op,
   input  logic        d_load,
   input  logic [2:0]  d_branch_type,
   input  logic [3:0]  d_ROB_entry,
   input  logic [31:0] d_src1_val,
   input  logic [31:0] d_src2_val,
   input  logic        d_src1_rdy,
   input  logic        d_src2_rdy,
   input  logic [3:0]  d_src1_tag,
   input  logic [3:0]  d_src2_tag,
   input  logic        cdb_valid,
   input  logic [3:0]  cdb_tag,
   input  logic [31:0] cdb_value,
   input  logic [3:0]  consumed_bus,
   output rs_out_t     rs0_data,
   output rs_out_t     rs1_data,
   output rs_out_t     rs2_data,
   output rs_out_t     rs3_data,
   output logic [2:0]  occupancy
);

   rs_ent_t    r_ent [4];
   logic [2:0] r_occ;

   rs_ent_t    w_nxt [4];
   rs_ent_t    w_new;
   rs_out_t    w_out [4];
   logic       w_disp;
   logic       w_found;
   logic [1:0] w_slot;
   logic [2:0] w_cnt;
   logic       w_hit1;
   logic       w_hit2;

   assign dispatch_ready = (r_occ < 3'd4);
   assign occupancy      = r_occ;
   assign w_disp         = dispatch_valid & dispatch_ready & ~flush;

   // Incoming operands can be satisfied by a broadcast in the same cycle.
   assign w_hit1 = ~d_src1_rdy & cdb_valid & (cdb_tag == d_src1_tag);
   assign w_hit2 = ~d_src2_rdy & cdb_valid & (cdb_tag == d_src2_tag);

   always_comb begin
      w_new      = '0;
      w_new.busy = 1'b1;
      w_new.alu  = d_ALU_op;
      w_new.load = d_load;
      w_new.br   = d_branch_type;
      w_new.rob  = d_ROB_entry;
      w_new.v1   = w_hit1 ? cdb_value : d_src1_val;
      w_new.r1   = d_src1_rdy | w_hit1;
      w_new.t1   = d_src1_tag;
      w_new.v2   = w_hit2 ? cdb_value : d_src2_val;
      w_new.r2   = d_src2_rdy | w_hit2;
      w_new.t2   = d_src2_tag;
   end

   // A busy entry (even one consumed this cycle) is never a dispatch target.
   always_comb begin
      w_found = 1'b0;
      w_slot  = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!w_found && !r_ent[i].busy) begin
            w_found = 1'b1;
            w_slot  = 2'(i);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_nxt[i] = r_ent[i];
         if (r_ent[i].busy && cdb_valid) begin
            if (!r_ent[i].r1 && r_ent[i].t1 == cdb_tag) begin
               w_nxt[i].v1 = cdb_value;
               w_nxt[i].r1 = 1'b1;
            end
            if (!r_ent[i].r2 && r_ent[i].t2 == cdb_tag) begin
               w_nxt[i].v2 = cdb_value;
               w_nxt[i].r2 = 1'b1;
            end
         end
         // Consume beats wakeup on the same entry.
         if (r_ent[i].busy && consumed_bus[i])
            w_nxt[i] = '0;
      end
      if (w_disp && w_found)
         w_nxt[w_slot] = w_new;
      if (flush)
         for (int i = 0; i < 4; i++)
            w_nxt[i] = '0;
   end

   always_comb begin
      w_cnt = 3'd0;
      for (int i = 0; i < 4; i++)
         w_cnt = w_cnt + 3'(w_nxt[i].busy);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++)
            r_ent[i] <= '0;
         r_occ <= 3'd0;
      end else begin
         for (int i = 0; i < 4; i++)
            r_ent[i] <= w_nxt[i];
         r_occ <= w_cnt;
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_out[i]             = '0;
         w_out[i].branch_type = NB;
         if (r_ent[i].busy) begin
            w_out[i].valid_operands = r_ent[i].r1 & r_ent[i].r2;
            w_out[i].ALU_op         = r_ent[i].alu;
            w_out[i].load           = r_ent[i].load;
            w_out[i].branch_type    = r_ent[i].br;
            w_out[i].ROB_entry      = r_ent[i].rob;
            w_out[i].rs1            = r_ent[i].v1;
            w_out[i].rs2            = r_ent[i].v2;
         end
      end
   end

   assign rs0_data = w_out[0];
   assign rs1_data = w_out[1];
   assign rs2_data = w_out[2];
   assign rs3_data = w_out[3];

endmodule

// File: doc/reservation_stations.md
RESERVATION_STATIONS -- requirements
Module: reservation_stations

Interface
REQ-001 SHALL have no parameters; the entry count is fixed at 4 and tags are 4 bits (ROB index).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port flush, input, 1 bit: synchronous clear of all entries (mispredict recovery).
REQ-005 SHALL have port dispatch_valid, input, 1 bit: a new instruction is presented this cycle.
REQ-006 SHALL have port dispatch_ready, output, 1 bit: at least one entry is free.
REQ-007 SHALL have ports d_ALU_op (4 bits), d_load (1), d_branch_type (3) and d_ROB_entry (4), all inputs: fields of the instruction being dispatched.
REQ-008 SHALL have ports d_src1_val and d_src2_val, input, 32 bits each: operand values.
REQ-009 SHALL have ports d_src1_rdy and d_src2_rdy, input, 1 bit each: the matching operand value is already valid.
REQ-010 SHALL have ports d_src1_tag and d_src2_tag, input, 4 bits each: producing ROB entry of an operand that is not yet ready.
REQ-011 SHALL have ports cdb_valid (1), cdb_tag (4) and cdb_value (32), all inputs: the result broadcast bus.
REQ-012 SHALL have port consumed_bus, input, 4 bits, one-hot or zero: the issue scheduler has taken entry i.
REQ-013 SHALL have ports rs0_data, rs1_data, rs2_data and rs3_data, output, rs_out_t each: entry contents presented to the scheduler.
REQ-014 SHALL have port occupancy, output, 3 bits: number of busy entries (0-4).

Function
REQ-015 Each entry SHALL hold: busy, ALU_op, load, branch_type, ROB_entry, and for each of its two operands a value, a ready bit and a tag.
REQ-016 rsN_data.valid_operands SHALL equal busy AND src1 ready AND src2 ready, decoded combinationally from the registered entry state.
REQ-017 rsN_data.rs1 and .rs2 SHALL carry the stored operand values.
REQ-018 A non-busy entry SHALL drive every rs_out_t field as zero, except branch_type, which SHALL be NB.
REQ-019 dispatch_ready SHALL be 1 when occupancy < 4.
REQ-020 A dispatch SHALL occur when dispatch_valid and dispatch_ready are both 1 and flush is 0.
REQ-021 A dispatch SHALL write the lowest-indexed entry that is free in the current-cycle state, and that entry SHALL be busy at the next edge.
REQ-022 An entry being consumed in the same cycle SHALL NOT count as free.
REQ-023 When dispatch_valid is 1 and dispatch_ready is 0, the request SHALL be ignored with no state change.
REQ-024 Dispatch-time bypass: if an operand arrives not ready and its tag equals cdb_tag while cdb_valid is 1, the entry SHALL store cdb_value with the ready bit set.
REQ-025 Wakeup: every busy entry whose operand is not ready and whose tag equals cdb_tag while cdb_valid is 1 SHALL capture cdb_value and set that ready bit at the edge.
REQ-026 Wakeup SHALL apply to both operands of an entry in the same cycle, and to any number of entries at once.
REQ-027 Latency: valid_operands SHALL rise exactly one cycle after the CDB broadcast (or dispatch) that completes the operands.
REQ-028 Operands that are already ready SHALL ignore the CDB.
REQ-029 consumed_bus[i]=1 on a busy entry SHALL clear it at the next edge; the entry is free from the following cycle.
REQ-030 consumed_bus[i]=1 on a non-busy entry SHALL be ignored.
REQ-031 Consume and wakeup of the same entry in the same cycle: consume SHALL win.
REQ-032 flush=1 SHALL clear every busy bit at the next edge; it overrides dispatch, wakeup and consume.
REQ-033 occupancy SHALL be registered and SHALL equal the population count of the busy bits.

Reset
REQ-034 reset=1 SHALL immediately (asynchronously) clear all busy bits, operand ready bits, values and tags.
REQ-035 While reset is held: outputs SHALL be zero / NB, occupancy SHALL be 0 and dispatch_ready SHALL be 1.
REQ-036 Reset asserted mid-operation SHALL discard all pending entries, with no partial wakeup.
REQ-037 The first dispatch after reset deassertion SHALL go to entry 0.

Verification
REQ-038 Reset, then dispatch ADD with both operands ready (5, 7), ROB 3 -> next cycle rs0_data.valid_operands=1, rs1=5, rs2=7, ROB_entry=3, occupancy=1.
REQ-039 Dispatch with src1 not ready, tag 9; two cycles later cdb_valid=1, tag 9, value 0xDEADBEEF -> valid_operands=1 one cycle after the broadcast, with rs1=0xDEADBEEF.
REQ-040 Dispatch in the same cycle as a CDB broadcast of the matching tag 4, value 42 -> entry is valid next cycle with rs2=42.
REQ-041 Fill all 4 entries -> dispatch_ready=0 and a 5th dispatch is ignored; consumed_bus=4'b0100 -> entry 2 frees and the next dispatch lands in entry 2.
REQ-042 Two entries both waiting on tag 6 receive a single broadcast -> both become valid in the same cycle.
REQ-043 Apply flush with dispatch_valid=1 and 3 entries busy -> occupancy=0 and no entry busy next cycle; reset mid-wakeup clears everything asynchronously.
